// File: rtl/instruction_fetch.sv
// Instruction fetch stage: req/ack imem port, IF/ID register, skid buffer.
// Drives the PC write enable; discards responses squashed by a redirect.
module instruction_fetch #(
   parameter int unsigned    AW  = 32,
   parameter int unsigned    IW  = 32,
   parameter logic [IW-1:0]  NOP = '0
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic [AW-1:0] pc,
   output logic          wpcir,
   input  logic          redirect,
   input  logic          id_stall,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic [IW-1:0] dinst,
   output logic [AW-1:0] dpc4,
   output logic          dvalid
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DROP
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] skid_inst;
   logic [AW-1:0] skid_pc4;
   logic [AW-1:0] drop_addr;
   logic [AW-1:0] pc4;

   assign pc4 = pc + AW'(4);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = FETCH;
         FETCH: begin
            if (redirect)
               state_nx = imem_ack ? FETCH : DROP;
            else if (imem_ack && id_stall)
               state_nx = HOLD;
         end
         HOLD: begin
            if (redirect || !id_stall) state_nx = FETCH;
         end
         DROP: begin
            if (!redirect && imem_ack) state_nx = FETCH;
         end
         default: state_nx = IDLE;
      endcase
   end

   // pc only moves on a consumed response or a redirect
   always_comb begin
      imem_req  = (state == FETCH) || (state == DROP);
      imem_addr = (state == DROP) ? drop_addr : pc;
      wpcir     = clrn &&
                  (redirect || (state == FETCH && imem_ack));
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         dinst     <= NOP;
         dpc4      <= '0;
         dvalid    <= 1'b0;
         skid_inst <= NOP;
         skid_pc4  <= '0;
         drop_addr <= '0;
      end else begin
         if (redirect) begin
            dinst  <= NOP;
            dpc4   <= '0;
            dvalid <= 1'b0;
         end else begin
            case (state)
               FETCH: begin
                  if (imem_ack && !id_stall) begin
                     dinst  <= imem_rdata;
                     dpc4   <= pc4;
                     dvalid <= 1'b1;
                  end else if (imem_ack) begin
                     skid_inst <= imem_rdata;
                     skid_pc4  <= pc4;
                  end else if (!id_stall) begin
                     dinst  <= NOP;
                     dpc4   <= '0;
                     dvalid <= 1'b0;
                  end
               end
               HOLD: begin
                  if (!id_stall) begin
                     dinst  <= skid_inst;
                     dpc4   <= skid_pc4;
                     dvalid <= 1'b1;
                  end
               end
               DROP: begin
                  if (!id_stall) begin
                     dinst  <= NOP;
                     dpc4   <= '0;
                     dvalid <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
         if (state == FETCH && redirect && !imem_ack)
            drop_addr <= pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; the bench acts as PC register
// and instruction memory, stepping one clock per table row.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        clrn;
   logic [31:0] pc;
   logic        wpcir;
   logic        redirect;
   logic        id_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] dinst;
   logic [31:0] dpc4;
   logic        dvalid;

   int checks = 0;
   int passed = 0;

   instruction_fetch #(.AW(32), .IW(32), .NOP(32'h0)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .pc         (pc),
      .wpcir      (wpcir),
      .redirect   (redirect),
      .id_stall   (id_stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dinst      (dinst),
      .dpc4       (dpc4),
      .dvalid     (dvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        rd;
      logic        st;
      logic        ack;
      logic [31:0] rdata;
      logic        e_wpcir;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_dinst;
      logic [31:0] e_dpc4;
      logic        e_dvalid;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   vec_t v[$];

   function automatic vec_t mk(
      input logic [31:0] p, input logic r, input logic s,
      input logic a, input logic [31:0] d, input logic w,
      input logic q, input logic [31:0] ad, input logic [31:0] di,
      input logic [31:0] dp, input logic dv);
      vec_t t;
      t.pc = p; t.rd = r; t.st = s; t.ack = a; t.rdata = d;
      t.e_wpcir = w; t.e_req = q; t.e_addr = ad;
      t.e_dinst = di; t.e_dpc4 = dp; t.e_dvalid = dv;
      return t;
   endfunction

   initial begin
      //        pc           rd st ak rdata         w  q  addr
      //        dinst          dpc4          dv
      v.push_back(mk(32'hBFC00000, 0, 0, 1, 32'h11111111, 1, 1,
                     32'hBFC00000, 32'h11111111, 32'hBFC00004, 1));
      // zero-wait stream
      v.push_back(mk(32'h0, 0, 0, 1, 32'hA0A0A0A0, 1, 1, 32'h0,
                     32'hA0A0A0A0, 32'h4, 1));
      v.push_back(mk(32'h4, 0, 0, 1, 32'hA1A1A1A1, 1, 1, 32'h4,
                     32'hA1A1A1A1, 32'h8, 1));
      v.push_back(mk(32'h8, 0, 0, 1, 32'hA2A2A2A2, 1, 1, 32'h8,
                     32'hA2A2A2A2, 32'hC, 1));
      // wait states at 0x40
      v.push_back(mk(32'h40, 0, 0, 0, 32'h0, 0, 1, 32'h40,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h40, 0, 0, 0, 32'h0, 0, 1, 32'h40,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h40, 0, 0, 1, 32'hB0B0B0B0, 1, 1, 32'h40,
                     32'hB0B0B0B0, 32'h44, 1));
      // stall on ack at 0x10
      v.push_back(mk(32'h10, 0, 1, 1, 32'h8C220004, 1, 1, 32'h10,
                     32'hB0B0B0B0, 32'h44, 1));
      v.push_back(mk(32'h14, 0, 1, 0, 32'h0, 0, 0, 32'h14,
                     32'hB0B0B0B0, 32'h44, 1));
      v.push_back(mk(32'h14, 0, 0, 0, 32'h0, 0, 0, 32'h14,
                     32'h8C220004, 32'h14, 1));
      // redirect while waiting at 0x20
      v.push_back(mk(32'h20, 0, 0, 0, 32'h0, 0, 1, 32'h20,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h20, 1, 0, 0, 32'h0, 1, 1, 32'h20,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h100, 0, 0, 0, 32'h0, 0, 1, 32'h20,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h100, 0, 0, 1, 32'hDEADDEAD, 0, 1, 32'h20,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h100, 0, 0, 0, 32'h0, 0, 1, 32'h100,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h100, 0, 0, 1, 32'hC1C1C1C1, 1, 1, 32'h100,
                     32'hC1C1C1C1, 32'h104, 1));
      // redirect + ack + stall together
      v.push_back(mk(32'h104, 1, 1, 1, 32'hBADBAD00, 1, 1, 32'h104,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h200, 0, 1, 0, 32'h0, 0, 1, 32'h200,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h200, 0, 0, 1, 32'hC2C2C2C2, 1, 1, 32'h200,
                     32'hC2C2C2C2, 32'h204, 1));
      // pc+4 wraps
      v.push_back(mk(32'hFFFFFFFC, 0, 0, 1, 32'hC3C3C3C3, 1, 1,
                     32'hFFFFFFFC, 32'hC3C3C3C3, 32'h0, 1));
      // redirect out of HOLD drops the skid
      v.push_back(mk(32'h0, 0, 1, 1, 32'hC4C4C4C4, 1, 1, 32'h0,
                     32'hC3C3C3C3, 32'h0, 1));
      v.push_back(mk(32'h4, 1, 1, 0, 32'h0, 1, 0, 32'h4,
                     32'h0, 32'h0, 0));
      v.push_back(mk(32'h80, 0, 0, 1, 32'hC5C5C5C5, 1, 1, 32'h80,
                     32'hC5C5C5C5, 32'h84, 1));

      clrn       = 1'b0;
      pc         = 32'hBFC00000;
      redirect   = 1'b0;
      id_stall   = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_dvalid", {31'b0, dvalid}, 32'h0);
      @(negedge clk);
      clrn = 1'b1;
      #1;
      chk("idle_req", {31'b0, imem_req}, 32'h0);
      chk("idle_wpcir", {31'b0, wpcir}, 32'h0);
      @(posedge clk);
      #1;
      chk("first_req", {31'b0, imem_req}, 32'h1);
      chk("first_addr", imem_addr, 32'hBFC00000);
      chk("first_wpcir", {31'b0, wpcir}, 32'h0);

      foreach (v[i]) begin
         @(negedge clk);
         pc         = v[i].pc;
         redirect   = v[i].rd;
         id_stall   = v[i].st;
         imem_ack   = v[i].ack;
         imem_rdata = v[i].rdata;
         #1;
         chk($sformatf("v%0d_wpcir", i), {31'b0, wpcir},
             {31'b0, v[i].e_wpcir});
         chk($sformatf("v%0d_req", i), {31'b0, imem_req},
             {31'b0, v[i].e_req});
         if (v[i].e_req)
            chk($sformatf("v%0d_addr", i), imem_addr, v[i].e_addr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_dinst", i), dinst, v[i].e_dinst);
         chk($sformatf("v%0d_dpc4", i), dpc4, v[i].e_dpc4);
         chk($sformatf("v%0d_dvalid", i), {31'b0, dvalid},
             {31'b0, v[i].e_dvalid});
      end

      // async reset in the middle of an outstanding fetch
      @(negedge clk);
      redirect = 1'b0;
      id_stall = 1'b0;
      imem_ack = 1'b0;
      pc       = 32'h300;
      #1;
      chk("pre_rst_req", {31'b0, imem_req}, 32'h1);
      #2;
      clrn     = 1'b0;
      imem_ack = 1'b1;
      #1;
      chk("async_req", {31'b0, imem_req}, 32'h0);
      chk("async_wpcir", {31'b0, wpcir}, 32'h0);
      chk("async_dinst", dinst, 32'h0);
      chk("async_dpc4", dpc4, 32'h0);
      chk("async_dvalid", {31'b0, dvalid}, 32'h0);
      imem_ack = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      pc   = 32'hBFC00000;
      @(posedge clk);
      #1;
      chk("rel_req", {31'b0, imem_req}, 32'h1);
      chk("rel_addr", imem_addr, 32'hBFC00000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
